// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared SoC bus widths and requester index encoding for the data-memory path.
package dmem_arbiter_pkg;
  localparam int SOC_ADDR_W = 32;
  localparam int SOC_DATA_W = 32;
  typedef enum logic {M0 = 1'b0, M1 = 1'b1} req_idx_e;
endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-requester pick logic (round-robin or m0-priority with forced m1) producing a one-hot grant.
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  req_idx_e   ptr,
  input  logic       prio,
  input  logic       force_m1,
  output logic [1:0] gnt
);
  logic pick_m1;
  assign pick_m1 = prio ? force_m1 : (ptr == M0);
  assign gnt[M1] = req[M1] & (~req[M0] | pick_m1);
  assign gnt[M0] = req[M0] & ~gnt[M1];
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: arbitrates core (m0) and DMA/debug (m1) accesses onto one data-memory port.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = SOC_ADDR_W,
  parameter int DATA_W     = SOC_DATA_W,
  parameter int PRIO_M0    = 0,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic              m0_we,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [1:0]    pick;
  logic          any_gnt;
  logic          win_we;
  logic          rd_q;
  req_idx_e      last_q;
  req_idx_e      owner_q;
  req_idx_e      win;
  logic [SW-1:0] starve_q;
  rr_arb2 u_pick (
    .req      ({m1_req, m0_req}),
    .ptr      (last_q),
    .prio     (PRIO_M0 != 0),
    .force_m1 (starve_q == SW'(STARVE_MAX)),
    .gnt      (pick)
  );
  // Grants are masked while reset is held so no access escapes during reset.
  assign m0_gnt    = rst & pick[M0];
  assign m1_gnt    = rst & pick[M1];
  assign any_gnt   = m0_gnt | m1_gnt;
  assign win       = m1_gnt ? M1 : M0;
  assign win_we    = m1_gnt ? m1_we : m0_we;
  assign mem_addr  = m1_gnt ? m1_addr : m0_gnt ? m0_addr : '0;
  assign mem_wdata = m1_gnt ? m1_wdata : m0_gnt ? m0_wdata : '0;
  assign mem_write = any_gnt & win_we;
  assign mem_read  = any_gnt & ~win_we;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q   <= M1;
      owner_q  <= M0;
      rd_q     <= 1'b0;
      starve_q <= '0;
    end else begin
      if (any_gnt) last_q <= win;
      rd_q     <= mem_read;
      owner_q  <= win;
      starve_q <= (m1_req & ~m1_gnt) ? (starve_q == SW'(STARVE_MAX) ? starve_q : starve_q + 1'b1) : '0;
    end
  end
  assign m0_rvalid = rd_q & (owner_q == M0);
  assign m1_rvalid = rd_q & (owner_q == M1);
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;
endmodule
